hour_counter_fmt: RTL and testbench
===================================

# hour_counter_fmt

Parametrised time-field counter with a selectable 12/24-hour display format. It replaces the pair of independent 24 h and 12 h counters with a single binary count, so switching format never loses or desynchronises the time. It adds a carry/borrow chain, edge-detected edit buttons with optional auto-repeat, and BCD output with an AM/PM flag. It sits between the minute counter (tick source) and the display/RTC write path of the clock datapath.

## Interface

Parameters:
- MOD, 24: counter modulus; the count runs 0..MOD-1. Legal range is 2..99. MOD=60 reuses the block for minutes or seconds.
- RESET_VAL, 0: count loaded on reset. Must be < MOD.
- REPEAT_DELAY, 0: cycles a button must stay held before auto-repeat starts. 0 disables auto-repeat.
- REPEAT_PERIOD, 1: cycles between auto-repeat steps once repeat is active. Must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- EN  in  1  edit mode. 1 = up/down buttons act and tick is ignored. 0 = tick acts and buttons are ignored.
- tick  in  1  one-cycle increment pulse, e.g. the carry from the minute counter.
- up  in  1  increment button level, synchronous to clk.
- down  in  1  decrement button level, synchronous to clk.
- forma  in  1  display format. 0 = 24 h, 1 = 12 h. Only honoured when MOD=24; otherwise ignored.
- count  out  7  raw binary count, 0..MOD-1.
- Hora  out  8  BCD display value: [7:4] tens, [3:0] units.
- pm  out  1  1 when count ≥ 12 and MOD=24; else 0.
- carry_out  out  1  wrap MOD-1→0 caused by tick.
- borrow_out  out  1  wrap 0→MOD-1 caused by down.

## Operation

- The count register is the only state holding time. Hora, pm, carry_out and borrow_out are combinational decodes of registered state and the current inputs.
- Edge detect: up_q and down_q register the previous levels.
  - step_up = up & ~up_q.
  - step_dn = down & ~down_q.
- Auto-repeat (REPEAT_DELAY > 0):
  - A hold counter runs while exactly one of up/down is high. It clears on any release or when both are high.
  - When the hold counter reaches REPEAT_DELAY, the block issues a step. It then issues a further step every REPEAT_PERIOD cycles while the button stays held.
  - The hold counter saturates so it never wraps.
- Step resolution:
  - EN=1: up-step and down-step in the same cycle cancel (no change). Otherwise the count goes +1 or −1 modulo MOD. The tick input is ignored.
  - EN=0: tick increments modulo MOD. Buttons are ignored, but the edge registers still track the button levels.
- Wrap rules:
  - MOD-1 + 1 → 0.
  - 0 − 1 → MOD-1.
  - carry_out = ~EN & tick & (count==MOD-1).
  - borrow_out = EN & dn_step_effective & (count==0).
  - An up-step through MOD-1→0 in edit mode does not assert carry_out, because editing does not advance the day.
- Format decode when MOD=24 and forma=1:
  - 0 → 12, pm=0.
  - 1..11 → 1..11, pm=0.
  - 12 → 12, pm=1.
  - 13..23 → 1..11, pm=1.
- Otherwise Hora is the BCD of count directly.
- Changing forma mid-operation only changes the decode; count is unaffected.

## Timing

- Reset (asynchronous, takes effect immediately):
  - count=RESET_VAL.
  - up_q=down_q=0.
  - hold counter=0.
  - Outputs then reflect RESET_VAL: carry_out=borrow_out=0, pm and Hora decoded from RESET_VAL.
- Latency:
  - A step condition sampled at edge N is visible on count, Hora and pm after edge N.
  - No pipeline stage is placed on the outputs.
- A button held high through reset release counts as already seen (up_q is loaded from up at the first edge). It does not step unless auto-repeat fires.
- carry_out and borrow_out are high during the cycle before the wrapping edge, aligned with the causing tick or step, for exactly one cycle per event.
- Auto-repeat, with the rising edge sampled at edge N:
  - Edge-detected step at N.
  - First repeat step at N+REPEAT_DELAY.
  - Subsequent steps every REPEAT_PERIOD cycles.
- A reset asserted mid-hold or mid-repeat clears all state.
- Repeat restarts only after a fresh press.

## Test plan

- Reset with MOD=24, RESET_VAL=0, forma=0 → count=0, Hora=8'h00, pm=0. Set forma=1 → Hora=8'h12, pm=0 with no clock edge needed.
- EN=0, count=23, tick pulse → carry_out=1 during the tick cycle; after the edge count=0, Hora=8'h00 (24 h) or 8'h12 (12 h).
- EN=1, count=0, down pressed once → borrow_out=1; count=23. With forma=1: Hora=8'h11, pm=1.
- EN=1, up held 10 cycles with REPEAT_DELAY=4, REPEAT_PERIOD=2, starting from 5 → steps at cycles 0, 4, 6, 8 → count=9. Release and re-press → exactly one step.
- EN=1, up and down rising in the same cycle → count unchanged, no borrow_out or carry_out. EN=1 with a tick while count=23 → no change, carry_out=0.
- MOD=60, RESET_VAL=59, forma=1 → Hora=8'h59, pm=0. Tick → count=0, carry_out=1.

Source files
------------

// File: rtl/hour_counter_fmt.sv
// Binary time-field counter (hours, minutes or seconds) with tick carry, edit-mode
// up/down buttons with optional auto-repeat, and a 12/24 h BCD display decode.
module hour_counter_fmt #(
  parameter int MOD           = 24,
  parameter int RESET_VAL     = 0,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic       tick,
  input  logic       up,
  input  logic       down,
  input  logic       forma,
  output logic [6:0] count,
  output logic [7:0] Hora,
  output logic       pm,
  output logic       carry_out,
  output logic       borrow_out
);

  localparam logic [6:0] MAX_V   = 7'(MOD - 1);
  localparam logic [6:0] RESET_V = 7'(RESET_VAL);
  localparam bit         IS_HOUR = (MOD == 24);

  logic       up_q;
  logic       down_q;
  logic       armed;
  logic       rep_fire;
  logic       up_step;
  logic       dn_step;
  logic       up_eff;
  logic       dn_eff;
  logic       inc;
  logic       dec;
  logic [6:0] count_next;
  logic [6:0] disp;

  // armed stays low for the first edge after reset so a button already held
  // through reset release is taken as seen rather than as a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      up_q   <= up;
      down_q <= down;
      armed  <= 1'b1;
    end
  end

  generate
    if (REPEAT_DELAY > 0) begin : g_rep
      localparam int HW = $clog2(REPEAT_DELAY + 1);
      localparam int PW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
      localparam logic [HW-1:0] DELAY_V  = HW'(REPEAT_DELAY);
      localparam logic [PW-1:0] PER_LAST = PW'(REPEAT_PERIOD - 1);

      logic [HW-1:0] hold_cnt;
      logic [PW-1:0] per_cnt;
      logic          single;
      logic          at_delay;

      assign single   = up ^ down;
      assign at_delay = (hold_cnt == DELAY_V);

      // hold_cnt saturates at the delay; per_cnt then paces the repeat steps.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_cnt <= '0;
          per_cnt  <= '0;
        end else if (!single) begin
          hold_cnt <= '0;
          per_cnt  <= '0;
        end else if (!at_delay) begin
          hold_cnt <= hold_cnt + HW'(1);
        end else begin
          per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PW'(1);
        end
      end

      assign rep_fire = single & at_delay & (per_cnt == '0);
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end
  endgenerate

  assign up_step = (armed & up & ~up_q) | (rep_fire & up);
  assign dn_step = (armed & down & ~down_q) | (rep_fire & down);
  assign up_eff  = up_step & ~dn_step;
  assign dn_eff  = dn_step & ~up_step;

  assign inc = EN ? up_eff : tick;
  assign dec = EN & dn_eff;

  always_comb begin
    count_next = count;
    if (inc) begin
      count_next = (count == MAX_V) ? 7'd0 : count + 7'd1;
    end else if (dec) begin
      count_next = (count == 7'd0) ? MAX_V : count - 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_V;
    end else begin
      count <= count_next;
    end
  end

  assign carry_out  = ~EN & tick & (count == MAX_V);
  assign borrow_out = EN & dn_eff & (count == 7'd0);

  always_comb begin
    disp = count;
    if (IS_HOUR && forma) begin
      if (count == 7'd0) begin
        disp = 7'd12;
      end else if (count > 7'd12) begin
        disp = count - 7'd12;
      end
    end
  end

  assign Hora = {4'(disp / 7'd10), 4'(disp % 7'd10)};
  assign pm   = IS_HOUR && (count >= 7'd12);

endmodule

// File: tb/tb_hour_counter_fmt.sv
// Directed bench: a 24 h instance with auto-repeat and a 60-count instance
// starting at 59, both checked against hand-computed values.
module tb_hour_counter_fmt;

  logic       clk;
  logic       rst;
  logic       en_a, tick_a, up_a, down_a, forma_a;
  logic [6:0] count_a;
  logic [7:0] hora_a;
  logic       pm_a, carry_a, borrow_a;
  logic       en_b, tick_b, up_b, down_b, forma_b;
  logic [6:0] count_b;
  logic [7:0] hora_b;
  logic       pm_b, carry_b, borrow_b;

  int n_cmp;
  int n_bad;

  hour_counter_fmt #(.MOD(24), .RESET_VAL(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_a (
    .clk(clk), .rst(rst), .EN(en_a), .tick(tick_a), .up(up_a), .down(down_a),
    .forma(forma_a), .count(count_a), .Hora(hora_a), .pm(pm_a),
    .carry_out(carry_a), .borrow_out(borrow_a)
  );

  hour_counter_fmt #(.MOD(60), .RESET_VAL(59), .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) dut_b (
    .clk(clk), .rst(rst), .EN(en_b), .tick(tick_b), .up(up_b), .down(down_b),
    .forma(forma_b), .count(count_b), .Hora(hora_b), .pm(pm_b),
    .carry_out(carry_b), .borrow_out(borrow_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, ending on a falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    en_a = 0; tick_a = 0; up_a = 0; down_a = 0; forma_a = 0;
    en_b = 0; tick_b = 0; up_b = 0; down_b = 0; forma_b = 1;
    #2;
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_hora24", 32'(hora_a), 32'h00);
    check("rst_pm", 32'(pm_a), 32'd0);
    check("rst_carry", 32'(carry_a), 32'd0);
    check("rst_b_count", 32'(count_b), 32'd59);
    check("rst_b_hora", 32'(hora_b), 32'h59);
    check("rst_b_pm", 32'(pm_b), 32'd0);
    forma_a = 1;
    #1;
    check("rst_hora12", 32'(hora_a), 32'h12);
    check("rst_pm12", 32'(pm_a), 32'd0);
    forma_a = 0;
    @(negedge clk);
    rst = 1'b0;

    // tick up to 23
    tick_a = 1;
    step(23);
    tick_a = 0;
    check("tick_23_count", 32'(count_a), 32'd23);
    check("tick_23_hora", 32'(hora_a), 32'h23);
    check("tick_23_pm", 32'(pm_a), 32'd1);
    forma_a = 1;
    #1;
    check("fmt12_23_hora", 32'(hora_a), 32'h11);
    forma_a = 0;

    // wrap 23 -> 0 on tick
    tick_a = 1;
    #1;
    check("wrap_carry", 32'(carry_a), 32'd1);
    step(1);
    tick_a = 0;
    #1;
    check("wrap_count", 32'(count_a), 32'd0);
    check("wrap_hora24", 32'(hora_a), 32'h00);
    check("wrap_carry_drop", 32'(carry_a), 32'd0);
    forma_a = 1;
    #1;
    check("wrap_hora12", 32'(hora_a), 32'h12);

    // simultaneous up/down at 0: cancel
    en_a = 1;
    up_a = 1; down_a = 1;
    #1;
    check("both_borrow", 32'(borrow_a), 32'd0);
    check("both_carry", 32'(carry_a), 32'd0);
    step(1);
    up_a = 0; down_a = 0;
    check("both_count", 32'(count_a), 32'd0);
    step(1);

    // down at 0 borrows to 23
    down_a = 1;
    #1;
    check("dn_borrow", 32'(borrow_a), 32'd1);
    step(1);
    down_a = 0;
    #1;
    check("dn_count", 32'(count_a), 32'd23);
    check("dn_hora12", 32'(hora_a), 32'h11);
    check("dn_pm", 32'(pm_a), 32'd1);
    check("dn_borrow_drop", 32'(borrow_a), 32'd0);

    // tick ignored in edit mode
    tick_a = 1;
    #1;
    check("edit_tick_carry", 32'(carry_a), 32'd0);
    step(1);
    tick_a = 0;
    check("edit_tick_count", 32'(count_a), 32'd23);

    // up through 23 -> 0 in edit mode: no carry
    up_a = 1;
    #1;
    check("edit_wrap_carry", 32'(carry_a), 32'd0);
    step(1);
    up_a = 0;
    check("edit_wrap_count", 32'(count_a), 32'd0);

    // bring count to 5
    en_a = 0;
    tick_a = 1;
    step(5);
    tick_a = 0;
    check("pre_rep_count", 32'(count_a), 32'd5);

    // hold up 10 edges: steps at 0,4,6,8
    en_a = 1;
    forma_a = 0;
    up_a = 1;
    step(5);
    check("rep_mid_count", 32'(count_a), 32'd7);
    step(5);
    up_a = 0;
    check("rep_end_count", 32'(count_a), 32'd9);
    step(2);
    check("rep_idle_count", 32'(count_a), 32'd9);
    up_a = 1;
    step(3);
    up_a = 0;
    step(1);
    check("repress_count", 32'(count_a), 32'd10);
    check("repress_hora", 32'(hora_a), 32'h10);

    // 60-count instance: 59 -> 0 on tick
    tick_b = 1;
    #1;
    check("b_carry", 32'(carry_b), 32'd1);
    step(1);
    tick_b = 0;
    check("b_wrap_count", 32'(count_b), 32'd0);
    check("b_wrap_hora", 32'(hora_b), 32'h00);

    // button held through reset release does not step
    up_a = 1;
    rst = 1;
    #1;
    check("rst_mid_count", 32'(count_a), 32'd0);
    step(1);
    rst = 0;
    step(3);
    check("held_rst_count", 32'(count_a), 32'd0);
    up_a = 0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
